// File: rtl/flexsoc_chan_arb.sv
// Two-client channel arbiter over one shared host byte-stream FIFO pair.
// RX frames are demuxed by header channel bit; TX frames are granted round-robin per frame.
module flexsoc_chan_arb #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LENW   = 6,
  parameter int unsigned CH_BIT = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  output logic          com_rden_o,
  input  logic          com_rdempty_i,
  input  logic [DW-1:0] com_rddata_i,
  output logic          com_wren_o,
  input  logic          com_wrfull_i,
  output logic [DW-1:0] com_wrdata_o,

  input  logic          c1_rden_i,
  output logic          c1_rdempty_o,
  output logic [DW-1:0] c1_rddata_o,
  input  logic          c1_wrreq_i,
  input  logic          c1_wren_i,
  output logic          c1_wrfull_o,
  input  logic [DW-1:0] c1_wrdata_i,

  input  logic          c2_rden_i,
  output logic          c2_rdempty_o,
  output logic [DW-1:0] c2_rddata_o,
  input  logic          c2_wrreq_i,
  input  logic          c2_wren_i,
  output logic          c2_wrfull_o,
  input  logic [DW-1:0] c2_wrdata_i
);

  typedef logic [LENW:0]   rcnt_t;
  typedef logic [LENW-1:0] tcnt_t;

  typedef enum logic {RIdle, RRoute} rx_state_e;
  typedef enum logic [1:0] {TIdle, THdr, TData} tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  logic      ch_q, ch_d;
  rcnt_t     rcnt_q, rcnt_d;

  tx_state_e tx_state_q, tx_state_d;
  logic      g_q, g_d;
  logic      rr_q, rr_d;
  tcnt_t     tcnt_q, tcnt_d;

  logic          g_wren;
  logic [DW-1:0] g_wrdata;
  logic          unused_rddata;

  assign c1_rddata_o   = com_rddata_i;
  assign c2_rddata_o   = com_rddata_i;
  assign unused_rddata = ^com_rddata_i;

  always_comb begin
    rx_state_d   = rx_state_q;
    ch_d         = ch_q;
    rcnt_d       = rcnt_q;
    com_rden_o   = 1'b0;
    c1_rdempty_o = 1'b1;
    c2_rdempty_o = 1'b1;
    case (rx_state_q)
      RIdle: begin
        // Header is only peeked here; the selected client pops it itself.
        if (!com_rdempty_i) begin
          ch_d       = com_rddata_i[CH_BIT];
          rcnt_d     = rcnt_t'(com_rddata_i[LENW-1:0]) + rcnt_t'(1);
          rx_state_d = RRoute;
        end
      end
      RRoute: begin
        if (ch_q) begin
          c2_rdempty_o = com_rdempty_i;
          com_rden_o   = c2_rden_i & ~com_rdempty_i;
        end else begin
          c1_rdempty_o = com_rdempty_i;
          com_rden_o   = c1_rden_i & ~com_rdempty_i;
        end
        if (com_rden_o) begin
          rcnt_d = rcnt_q - rcnt_t'(1);
          if (rcnt_q == rcnt_t'(1)) rx_state_d = RIdle;
        end
      end
      default: rx_state_d = RIdle;
    endcase
  end

  assign g_wren   = g_q ? c2_wren_i : c1_wren_i;
  assign g_wrdata = g_q ? c2_wrdata_i : c1_wrdata_i;

  always_comb begin
    tx_state_d   = tx_state_q;
    g_d          = g_q;
    rr_d         = rr_q;
    tcnt_d       = tcnt_q;
    com_wren_o   = 1'b0;
    com_wrdata_o = '0;
    c1_wrfull_o  = 1'b1;
    c2_wrfull_o  = 1'b1;
    case (tx_state_q)
      TIdle: begin
        if (c1_wrreq_i || c2_wrreq_i) begin
          g_d        = (c1_wrreq_i && c2_wrreq_i) ? rr_q : c2_wrreq_i;
          tx_state_d = THdr;
        end
      end
      THdr, TData: begin
        if (g_q) c2_wrfull_o = com_wrfull_i;
        else     c1_wrfull_o = com_wrfull_i;
        com_wren_o   = g_wren & ~com_wrfull_i;
        com_wrdata_o = g_wrdata;
        if (com_wren_o) begin
          if (tx_state_q == THdr) begin
            tcnt_d = g_wrdata[LENW-1:0];
            if (g_wrdata[LENW-1:0] == '0) begin
              tx_state_d = TIdle;
              rr_d       = ~g_q;
            end else begin
              tx_state_d = TData;
            end
          end else begin
            tcnt_d = tcnt_q - tcnt_t'(1);
            if (tcnt_q == tcnt_t'(1)) begin
              tx_state_d = TIdle;
              rr_d       = ~g_q;
            end
          end
        end
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RIdle;
      ch_q       <= 1'b0;
      rcnt_q     <= '0;
      tx_state_q <= TIdle;
      g_q        <= 1'b0;
      rr_q       <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      ch_q       <= ch_d;
      rcnt_q     <= rcnt_d;
      tx_state_q <= tx_state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      tcnt_q     <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_flexsoc_chan_arb.sv
// Directed bench for flexsoc_chan_arb: FIFO models on the com side, per-client
// expected-byte queues for RX and one expected-byte queue for the TX FIFO.
module tb_flexsoc_chan_arb;

  logic       clk, rst_n;
  logic       com_rden, com_rdempty, com_wren, com_wrfull;
  logic [7:0] com_rddata, com_wrdata;
  logic       c1_rden, c1_rdempty, c1_wrreq, c1_wren, c1_wrfull;
  logic [7:0] c1_rddata, c1_wrdata;
  logic       c2_rden, c2_rdempty, c2_wrreq, c2_wren, c2_wrfull;
  logic [7:0] c2_rddata, c2_wrdata;

  int checks   = 0;
  int failures = 0;
  int tx_seen  = 0;
  int tx_exp_n = 0;

  logic [7:0] rxf[$];
  logic [7:0] exp_c1[$];
  logic [7:0] exp_c2[$];
  logic [7:0] exp_tx[$];
  logic       pop_now;

  flexsoc_chan_arb #(.DW(8), .LENW(6), .CH_BIT(7)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .com_rden_o   (com_rden),
    .com_rdempty_i(com_rdempty),
    .com_rddata_i (com_rddata),
    .com_wren_o   (com_wren),
    .com_wrfull_i (com_wrfull),
    .com_wrdata_o (com_wrdata),
    .c1_rden_i    (c1_rden),
    .c1_rdempty_o (c1_rdempty),
    .c1_rddata_o  (c1_rddata),
    .c1_wrreq_i   (c1_wrreq),
    .c1_wren_i    (c1_wren),
    .c1_wrfull_o  (c1_wrfull),
    .c1_wrdata_i  (c1_wrdata),
    .c2_rden_i    (c2_rden),
    .c2_rdempty_o (c2_rdempty),
    .c2_rddata_o  (c2_rddata),
    .c2_wrreq_i   (c2_wrreq),
    .c2_wren_i    (c2_wren),
    .c2_wrfull_o  (c2_wrfull),
    .c2_wrdata_i  (c2_wrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void rx_refresh();
    com_rdempty = (rxf.size() == 0);
    com_rddata  = (rxf.size() == 0) ? 8'h00 : rxf[0];
  endfunction

  task automatic rx_push(input logic [7:0] b);
    @(posedge clk);
    #2;
    rxf.push_back(b);
    rx_refresh();
  endtask

  // com_rden is sampled before the edge updates state; the FIFO pops just after.
  always @(posedge clk) begin
    pop_now = com_rden;
    #1;
    if (pop_now && rxf.size() > 0) begin
      void'(rxf.pop_front());
      rx_refresh();
    end
  end

  always @(posedge clk) begin
    if (rst_n && com_wren) begin
      tx_seen++;
      check("tx_byte", {24'h0, com_wrdata},
            (exp_tx.size() > 0) ? {24'h0, exp_tx.pop_front()} : 32'hdead);
    end
  end

  function automatic void push_tx_exp(input logic [7:0] h, input logic [7:0] base);
    exp_tx.push_back(h);
    tx_exp_n++;
    for (int i = 1; i <= int'(h[5:0]); i++) begin
      exp_tx.push_back(base + 8'(i));
      tx_exp_n++;
    end
  endfunction

  task automatic set_req(input int n, input logic v);
    if (n == 1) c1_wrreq = v;
    else        c2_wrreq = v;
  endtask

  task automatic set_wr(input int n, input logic en, input logic [7:0] d);
    if (n == 1) begin c1_wren = en; c1_wrdata = d; end
    else        begin c2_wren = en; c2_wrdata = d; end
  endtask

  function automatic logic wr_full(input int n);
    return (n == 1) ? c1_wrfull : c2_wrfull;
  endfunction

  // Holds wren while stalled, so a non-granted client keeps offering bytes.
  task automatic cli_tx(input int n, input logic [7:0] h, input logic [7:0] base);
    int idx = 0;
    int len = int'(h[5:0]) + 1;
    int t   = 0;
    @(negedge clk);
    set_req(n, 1'b1);
    while (idx < len && t < 300) begin
      if (idx > 0) set_req(n, 1'b0);
      set_wr(n, 1'b1, (idx == 0) ? h : base + 8'(idx));
      if (!wr_full(n)) idx++;
      t++;
      @(negedge clk);
    end
    set_wr(n, 1'b0, 8'h00);
    set_req(n, 1'b0);
    check("tx_sent", idx, len);
  endtask

  task automatic cli_rx(input int n, input int count, input logic other_rden);
    int got = 0;
    int t   = 0;
    logic [7:0] e;
    while (got < count && t < 300) begin
      @(negedge clk);
      if (n == 1) begin
        c1_rden = 1'b1;
        c2_rden = other_rden;
        if (!c1_rdempty) begin
          e = (exp_c1.size() > 0) ? exp_c1.pop_front() : 8'hxx;
          check("c1_rddata", {24'h0, c1_rddata}, {24'h0, e});
          check("c2_rdempty_idle", {31'h0, c2_rdempty}, 1);
          got++;
        end
      end else begin
        c2_rden = 1'b1;
        c1_rden = other_rden;
        if (!c2_rdempty) begin
          e = (exp_c2.size() > 0) ? exp_c2.pop_front() : 8'hxx;
          check("c2_rddata", {24'h0, c2_rddata}, {24'h0, e});
          check("c1_rdempty_idle", {31'h0, c1_rdempty}, 1);
          got++;
        end
      end
      t++;
    end
    @(negedge clk);
    c1_rden = 1'b0;
    c2_rden = 1'b0;
    check("rx_count", got, count);
  endtask

  initial begin
    rst_n = 1'b1;
    com_wrfull = 1'b0;
    c1_rden = 0; c1_wrreq = 0; c1_wren = 0; c1_wrdata = 0;
    c2_rden = 0; c2_wrreq = 0; c2_wren = 0; c2_wrdata = 0;
    rx_refresh();
    #1 rst_n = 1'b0;
    #2;
    check("rst_com_rden", {31'h0, com_rden}, 0);
    check("rst_com_wren", {31'h0, com_wren}, 0);
    check("rst_com_wrdata", {24'h0, com_wrdata}, 0);
    check("rst_c1_rdempty", {31'h0, c1_rdempty}, 1);
    check("rst_c2_rdempty", {31'h0, c2_rdempty}, 1);
    check("rst_c1_wrfull", {31'h0, c1_wrfull}, 1);
    check("rst_c2_wrfull", {31'h0, c2_wrfull}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // RX frame to c1 with a com-side empty gap mid-frame.
    exp_c1.push_back(8'h03); exp_c1.push_back(8'haa);
    exp_c1.push_back(8'hbb); exp_c1.push_back(8'hcc);
    fork
      cli_rx(1, 4, 1'b0);
      begin
        rx_push(8'h03); rx_push(8'haa);
        repeat (4) @(posedge clk);
        rx_push(8'hbb); rx_push(8'hcc);
      end
    join
    check("rx1_fifo_drained", rxf.size(), 0);

    // LEN=0 frame to c2, then c1 frame while c2 keeps rden high.
    rx_push(8'h80); rx_push(8'h01); rx_push(8'h55);
    exp_c2.push_back(8'h80);
    exp_c1.push_back(8'h01); exp_c1.push_back(8'h55);
    cli_rx(2, 1, 1'b0);
    cli_rx(1, 2, 1'b1);
    check("rx2_fifo_drained", rxf.size(), 0);

    // Both request with RR at c1: c1 frame then c2 frame.
    push_tx_exp(8'h02, 8'h10);
    push_tx_exp(8'h02, 8'h20);
    fork
      cli_tx(1, 8'h02, 8'h10);
      cli_tx(2, 8'h02, 8'h20);
    join
    check("tx_bytes_a", tx_seen, 6);

    // c1 alone (LEN=0) moves RR to c2; then both request with stall and RX traffic.
    push_tx_exp(8'h00, 8'h00);
    cli_tx(1, 8'h00, 8'h00);
    push_tx_exp(8'h04, 8'h40);
    push_tx_exp(8'h04, 8'h30);
    exp_c2.push_back(8'h82); exp_c2.push_back(8'h9a); exp_c2.push_back(8'h9b);
    fork
      cli_tx(1, 8'h04, 8'h30);
      cli_tx(2, 8'h04, 8'h40);
      begin
        repeat (3) @(posedge clk);
        #2 com_wrfull = 1'b1;
        @(negedge clk);
        check("stall_c2_wrfull", {31'h0, c2_wrfull}, 1);
        check("stall_c1_wrfull", {31'h0, c1_wrfull}, 1);
        check("stall_com_wren", {31'h0, com_wren}, 0);
        repeat (3) @(posedge clk);
        #2 com_wrfull = 1'b0;
        @(negedge clk);
        check("resume_c2_wrfull", {31'h0, c2_wrfull}, 0);
        check("resume_c1_wrfull", {31'h0, c1_wrfull}, 1);
      end
      cli_rx(2, 3, 1'b0);
      begin
        rx_push(8'h82); rx_push(8'h9a); rx_push(8'h9b);
      end
    join
    check("tx_bytes_b", tx_seen, 17);

    // Reset mid-frame: header 0x05 popped, cnt=5; leftover bytes form a new c2 frame.
    rx_push(8'h05); rx_push(8'h81); rx_push(8'h77);
    exp_c1.push_back(8'h05);
    cli_rx(1, 1, 1'b0);
    @(negedge clk);
    c1_rden = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_com_rden", {31'h0, com_rden}, 0);
    check("mid_rst_c1_rdempty", {31'h0, c1_rdempty}, 1);
    check("mid_rst_c2_rdempty", {31'h0, c2_rdempty}, 1);
    @(negedge clk);
    c1_rden = 1'b0;
    rst_n = 1'b1;
    exp_c2.push_back(8'h81); exp_c2.push_back(8'h77);
    cli_rx(2, 2, 1'b0);
    check("rx3_fifo_drained", rxf.size(), 0);

    repeat (3) @(negedge clk);
    check("exp_c1_empty", exp_c1.size(), 0);
    check("exp_c2_empty", exp_c2.size(), 0);
    check("exp_tx_empty", exp_tx.size(), 0);
    check("tx_total", tx_seen, tx_exp_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
